// File: rtl/irq_ctrl.sv
// Priority interrupt controller between peripheral request lines and the CPU core.
//
// Level requests are gated by the global interrupt enable. The lowest-numbered active source
// wins. Its vector (index + VEC_OFFSET) is presented to the CPU together with cpu_irq. When
// the CPU accepts the request, the winning source gets a one-cycle interrupt_executed pulse
// so that it clears its flag. After RETI there is one gap cycle before a new request can be
// arbitrated.
//
// Ports:
//   clk                          system clock, rising edge
//   rst                          asynchronous active-high reset
//   irq_req[NUM_SRC]             level requests, bit i = source i (0 = highest priority)
//   status_reg_interrupt_enable  global I-flag
//   cpu_ack                      CPU accepts the presented interrupt (pulse)
//   cpu_reti                     CPU executed return-from-interrupt (pulse)
//   cpu_irq                      interrupt request to the CPU (registered)
//   cpu_vector[VEC_W]            vector of the presented interrupt (registered)
//   interrupt_executed[NUM_SRC]  one-hot, one-cycle pulse to the serviced source (registered)
//   in_service                   high while a handler is active (registered)
module irq_ctrl #(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned VEC_OFFSET = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               status_reg_interrupt_enable,
  input  logic               cpu_ack,
  input  logic               cpu_reti,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   cpu_vector,
  output logic [NUM_SRC-1:0] interrupt_executed,
  output logic               in_service
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StServ,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [VEC_W-1:0]   cpu_vector_q, cpu_vector_d;
  logic [NUM_SRC-1:0] executed_q, executed_d;
  logic               in_service_q, in_service_d;

  logic [IdxW-1:0]    winner;
  logic [VEC_W-1:0]   winner_vec;
  logic               valid;
  logic               ack_ok;

  // Priority encoder: iterate from the top so the lowest set bit is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        winner = IdxW'(i);
      end
    end
  end

  assign winner_vec = VEC_W'(winner) + VEC_W'(VEC_OFFSET);
  assign valid      = (|irq_req) && status_reg_interrupt_enable;
  // An ack only counts while the latched source still requests; otherwise cancel wins.
  assign ack_ok     = cpu_ack && irq_req[idx_q];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cpu_irq_d    = 1'b0;
    cpu_vector_d = cpu_vector_q;
    executed_d   = '0;
    in_service_d = in_service_q;

    unique case (state_q)
      StIdle: begin
        in_service_d = 1'b0;
        if (valid) begin
          state_d      = StPend;
          idx_d        = winner;
          cpu_vector_d = winner_vec;
          cpu_irq_d    = 1'b1;
        end
      end

      StPend: begin
        if (ack_ok) begin
          // Vector is left frozen at its value at ack.
          state_d           = StServ;
          executed_d[idx_q] = 1'b1;
          in_service_d      = 1'b1;
        end else if (valid) begin
          // Re-arbitrate every cycle so a higher-priority source preempts the pending one
          // without cpu_irq dropping.
          idx_d        = winner;
          cpu_vector_d = winner_vec;
          cpu_irq_d    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      StServ: begin
        if (cpu_reti) begin
          state_d      = StGap;
          in_service_d = 1'b0;
        end
      end

      StGap: begin
        // One instruction executes after RETI before any new request is considered.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cpu_irq_q    <= 1'b0;
      cpu_vector_q <= '0;
      executed_q   <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cpu_irq_q    <= cpu_irq_d;
      cpu_vector_q <= cpu_vector_d;
      executed_q   <= executed_d;
      in_service_q <= in_service_d;
    end
  end

  assign cpu_irq            = cpu_irq_q;
  assign cpu_vector         = cpu_vector_q;
  assign interrupt_executed = executed_q;
  assign in_service         = in_service_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Priority interrupt controller between the peripheral blocks (timer/counters, etc.) and the CPU core.
- Collects level interrupt requests from up to NUM_SRC peripherals and gates them with the status-register global interrupt enable.
- Presents the highest-priority request to the CPU as a single request plus vector.
- Returns a one-cycle executed pulse to the winning peripheral, which clears its flag and drops its request.

Parameters:
NUM_SRC, 8, number of interrupt sources; index 0 is highest priority.
VEC_W, 8, width of the vector output.
VEC_OFFSET, 1, vector = source index + VEC_OFFSET (vector 0 reserved for reset).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
irq_req  input  NUM_SRC  level requests from peripherals; bit i = source i.
status_reg_interrupt_enable  input  1  global I-flag from CPU status register.
cpu_ack  input  1  CPU accepts the presented interrupt (one-cycle pulse).
cpu_reti  input  1  CPU executed return-from-interrupt (one-cycle pulse).
cpu_irq  output  1  interrupt request to CPU.
cpu_vector  output  VEC_W  vector of the presented interrupt.
interrupt_executed  output  NUM_SRC  one-hot, one-cycle pulse to the serviced source.
in_service  output  1  high while a handler is active.

Behaviour:
- Reset (async, rst=1): state=IDLE; cpu_irq=0, cpu_vector=0, interrupt_executed=0, in_service=0, latched index=0.
- Arbitration (combinational): winner = lowest set bit of irq_req; valid = |irq_req && status_reg_interrupt_enable.
- All outputs are registered.
- States:
  - IDLE: if valid, latch winner index, go PEND; cpu_irq=1 and cpu_vector=index+VEC_OFFSET from the next cycle (1-cycle latency from req to cpu_irq).
  - PEND: cpu_irq=1.
    - Re-arbitrate each cycle: if a higher-priority source rises, update the latched index and vector (no cycle where cpu_irq drops).
    - If irq_req[latched] falls and no other source is valid, or enable falls: go IDLE, cpu_irq=0 next cycle (request cancelled, no executed pulse).
    - If cpu_ack=1: go SERV; interrupt_executed[latched]=1 for exactly one cycle; cpu_irq=0; in_service=1. Vector is frozen at its value at ack.
  - SERV: in_service=1, cpu_irq=0 regardless of irq_req.
    - On cpu_reti go GAP; in_service=0.
  - GAP: exactly one cycle with cpu_irq=0 (one instruction executes after RETI), then IDLE.
- Rules:
  - No nesting: requests during SERV/GAP stay pending at the source and are arbitrated in IDLE.
  - cpu_ack outside PEND is ignored.
  - cpu_reti outside SERV is ignored.
  - cpu_ack and a cancel condition in the same PEND cycle: ack wins when irq_req[latched] was still 1 that cycle; otherwise cancel wins.
  - Simultaneous requests: lower index always wins. Higher index is presented after the GAP if still asserted.
  - rst mid-operation (any state): immediate return to reset values; no executed pulse generated.
  - cpu_vector holds its last value in IDLE/SERV/GAP. It is only meaningful while cpu_irq=1.

Test Plan:
- Reset then irq_req=8'h04, enable=1 -> cpu_irq=1 one cycle later, cpu_vector=3; cpu_ack pulse -> interrupt_executed=8'h04 for one cycle, in_service=1, cpu_irq=0.
- irq_req=8'h0C simultaneously -> vector=3 first; after ack, source 2 drops, cpu_reti -> one GAP cycle with cpu_irq=0, then cpu_irq=1 with vector=4.
- Timer request (bit 5) pending with vector=6, then bit 1 rises before ack -> vector changes to 2 with cpu_irq held 1; ack pulses interrupt_executed=8'h02.
- Request present but enable=0 -> cpu_irq stays 0. Enable rises -> cpu_irq=1 next cycle. Enable falls in PEND -> cpu_irq=0 next cycle, no executed pulse.
- New request arrives in SERV -> cpu_irq stays 0 until cpu_reti + 1 GAP cycle. Stray cpu_ack in IDLE and stray cpu_reti in PEND -> no state change.
- Assert rst during SERV and during PEND -> all outputs 0 immediately. After release with irq_req still high -> normal 1-cycle re-presentation.
